dual_port_ram_fifo_controller: RTL and testbench

Pointer and flag controller that turns an external dual_port_ram instance into a synchronous first-word-fall-through FIFO. It sits directly upstream of the RAM.
- Drives the RAM write port and read address from valid/ready handshakes.
- Returns the RAM's combinational read data to the consumer.
Used wherever the design needs a RAM-backed FIFO deeper than a register FIFO.

---
 rtl/dual_port_ram_fifo_controller_if.sv | 30 +++
 rtl/dual_port_ram_fifo_controller.sv | 84 ++++++++
 tb/tb_dual_port_ram_fifo_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_fifo_controller_if.sv
// Producer/consumer handshake bundle for the RAM-backed FIFO controller.
// The controller uses the slave modport; whoever feeds and drains it uses master.
interface dual_port_ram_fifo_controller_if #(
  parameter int WIDTH = 8
);
  logic             write_valid;
  logic             write_ready;
  logic [WIDTH-1:0] write_data;
  logic             read_valid;
  logic             read_ready;
  logic [WIDTH-1:0] read_data;

  modport master (
    output write_valid,
    output write_data,
    input  write_ready,
    input  read_valid,
    input  read_data,
    output read_ready
  );

  modport slave (
    input  write_valid,
    input  write_data,
    output write_ready,
    output read_valid,
    output read_data,
    input  read_ready
  );
endinterface

// File: rtl/dual_port_ram_fifo_controller.sv
// Pointer/level controller turning an external dual-port RAM into a first-word-fall-through FIFO.
// Write-to-read latency is one cycle; write_ready = !full, read_valid = !empty, both from registered level only.
module dual_port_ram_fifo_controller #(
  parameter int WIDTH                  = 8,
  parameter int DEPTH                  = 16,
  parameter int ADDRESS_WIDTH          = $clog2(DEPTH),
  parameter int LEVEL_WIDTH            = $clog2(DEPTH + 1),
  parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  dual_port_ram_fifo_controller_if.slave fifo,
  output logic                     ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_write_address,
  output logic [WIDTH-1:0]         ram_write_data,
  output logic                     ram_read_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  input  logic [WIDTH-1:0]         ram_read_data,
  output logic [LEVEL_WIDTH-1:0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS  = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [LEVEL_WIDTH-1:0]   LEVEL_FULL    = LEVEL_WIDTH'(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0]   LEVEL_AFULL   = LEVEL_WIDTH'(ALMOST_FULL_THRESHOLD);
  localparam logic [LEVEL_WIDTH-1:0]   LEVEL_AEMPTY  = LEVEL_WIDTH'(ALMOST_EMPTY_THRESHOLD);

  logic [ADDRESS_WIDTH-1:0] write_pointer, write_pointer_next;
  logic [ADDRESS_WIDTH-1:0] read_pointer, read_pointer_next;
  logic [LEVEL_WIDTH-1:0]   level_q, level_next;
  logic                     write_fire;
  logic                     read_fire;

  // Explicit wrap so non-power-of-two depths never address past the last entry.
  function automatic logic [ADDRESS_WIDTH-1:0] advance(input logic [ADDRESS_WIDTH-1:0] ptr);
    return (ptr == LAST_ADDRESS) ? '0 : ptr + ADDRESS_WIDTH'(1);
  endfunction

  assign full         = (level_q == LEVEL_FULL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LEVEL_AFULL);
  assign almost_empty = (level_q <= LEVEL_AEMPTY);
  assign level        = level_q;

  assign fifo.write_ready = !full;
  assign fifo.read_valid  = !empty;
  assign fifo.read_data   = ram_read_data;

  assign write_fire = fifo.write_valid && !full;
  assign read_fire  = fifo.read_ready && !empty;

  assign ram_write_enable  = write_fire;
  assign ram_write_address = write_pointer;
  assign ram_write_data    = fifo.write_data;
  assign ram_read_enable   = !empty;
  assign ram_read_address  = read_pointer;

  always_comb begin
    write_pointer_next = write_pointer;
    read_pointer_next  = read_pointer;
    level_next         = level_q;
    if (write_fire) write_pointer_next = advance(write_pointer);
    if (read_fire)  read_pointer_next  = advance(read_pointer);
    if (write_fire && !read_fire)      level_next = level_q + LEVEL_WIDTH'(1);
    else if (read_fire && !write_fire) level_next = level_q - LEVEL_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      level_q       <= '0;
    end else begin
      write_pointer <= write_pointer_next;
      read_pointer  <= read_pointer_next;
      level_q       <= level_next;
    end
  end

endmodule

// File: tb/tb_dual_port_ram_fifo_controller.sv
// Directed bench: DEPTH=16 and DEPTH=5 controllers, each backed by a small behavioural dual-port RAM.
module tb_dual_port_ram_fifo_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;

  // ---------------- DEPTH=16 instance ----------------
  dual_port_ram_fifo_controller_if #(.WIDTH(8)) fa ();
  logic       a_we, a_re;
  logic [3:0] a_wa, a_ra;
  logic [7:0] a_wd, a_rd;
  logic [4:0] a_level;
  logic       a_full, a_empty, a_afull, a_aempty;
  logic [7:0] mem_a [16];

  dual_port_ram_fifo_controller #(.WIDTH(8), .DEPTH(16)) dut_a (
    .clock(clock), .reset(reset), .fifo(fa),
    .ram_write_enable(a_we), .ram_write_address(a_wa), .ram_write_data(a_wd),
    .ram_read_enable(a_re), .ram_read_address(a_ra), .ram_read_data(a_rd),
    .level(a_level), .full(a_full), .empty(a_empty),
    .almost_full(a_afull), .almost_empty(a_aempty)
  );

  always @(posedge clock) if (a_we) mem_a[a_wa] <= a_wd;
  assign a_rd = a_re ? mem_a[a_ra] : 8'h00;

  // ---------------- DEPTH=5 instance ----------------
  dual_port_ram_fifo_controller_if #(.WIDTH(8)) fb ();
  logic       b_we, b_re;
  logic [2:0] b_wa, b_ra;
  logic [7:0] b_wd, b_rd;
  logic [2:0] b_level;
  logic       b_full, b_empty, b_afull, b_aempty;
  logic [7:0] mem_b [5];

  dual_port_ram_fifo_controller #(.WIDTH(8), .DEPTH(5)) dut_b (
    .clock(clock), .reset(reset), .fifo(fb),
    .ram_write_enable(b_we), .ram_write_address(b_wa), .ram_write_data(b_wd),
    .ram_read_enable(b_re), .ram_read_address(b_ra), .ram_read_data(b_rd),
    .level(b_level), .full(b_full), .empty(b_empty),
    .almost_full(b_afull), .almost_empty(b_aempty)
  );

  always @(posedge clock) if (b_we && b_wa < 3'd5) mem_b[b_wa] <= b_wd;
  assign b_rd = (b_re && b_ra < 3'd5) ? mem_b[b_ra] : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    fa.write_valid = 1'b0; fa.write_data = '0; fa.read_ready = 1'b0;
    fb.write_valid = 1'b0; fb.write_data = '0; fb.read_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset / idle state
    check("rst_level",     a_level, 0);
    check("rst_empty",     a_empty, 1);
    check("rst_full",      a_full, 0);
    check("rst_aempty",    a_aempty, 1);
    check("rst_afull",     a_afull, 0);
    check("rst_wready",    fa.write_ready, 1);
    check("rst_rvalid",    fa.read_valid, 0);
    check("rst_rdata",     fa.read_data, 8'h00);
    check("rst_ram_we",    a_we, 0);

    // Single write then read; no same-cycle bypass
    fa.write_valid = 1'b1; fa.write_data = 8'h11;
    #1;
    check("w1_ram_we",     a_we, 1);
    check("w1_ram_wa",     a_wa, 0);
    check("w1_no_bypass",  fa.read_valid, 0);
    tick();
    fa.write_valid = 1'b0;
    #1;
    check("w1_rvalid",     fa.read_valid, 1);
    check("w1_rdata",      fa.read_data, 8'h11);
    check("w1_level",      a_level, 1);
    fa.read_ready = 1'b1;
    tick();
    fa.read_ready = 1'b0;
    #1;
    check("r1_empty",      a_empty, 1);
    check("r1_level",      a_level, 0);

    // Fresh fill of 0x00..0x0F
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fa.write_valid = 1'b1; fa.write_data = 8'(i);
      tick();
      check($sformatf("fill_level_%0d", i + 1), a_level, i + 1);
      check($sformatf("fill_afull_%0d", i + 1), a_afull, (i + 1 >= 14) ? 1 : 0);
      check($sformatf("fill_aempty_%0d", i + 1), a_aempty, (i + 1 <= 2) ? 1 : 0);
    end
    check("full_flag",     a_full, 1);
    check("full_wready",   fa.write_ready, 0);
    fa.write_data = 8'hAA;
    #1;
    check("full_no_we",    a_we, 0);
    tick();
    check("full_hold",     a_level, 16);

    // Read and write together at full: only the read happens
    fa.read_ready = 1'b1;
    #1;
    check("fr_rdata",      fa.read_data, 8'h00);
    check("fr_no_we",      a_we, 0);
    tick();
    fa.read_ready = 1'b0;
    #1;
    check("fr_level",      a_level, 15);
    check("fr_wready",     fa.write_ready, 1);
    check("fr_we",         a_we, 1);
    check("fr_wrap_addr",  a_wa, 0);
    tick();
    fa.write_valid = 1'b0;
    check("fr_refull",     a_level, 16);
    fa.read_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      #1;
      check($sformatf("drain_%0d", i), fa.read_data, 8'(i));
      tick();
    end
    #1;
    check("drain_aa",      fa.read_data, 8'hAA);
    tick();
    fa.read_ready = 1'b0;
    check("drain_empty",   a_empty, 1);

    // DEPTH=5 streaming through the wrap
    fb.write_valid = 1'b1; fb.write_data = 8'h20;
    tick();
    for (int k = 1; k < 12; k++) begin
      fb.write_valid = 1'b1; fb.write_data = 8'(8'h20 + k);
      fb.read_ready  = 1'b1;
      #1;
      check($sformatf("s5_rdata_%0d", k), fb.read_data, 8'h20 + k - 1);
      check($sformatf("s5_wa_%0d", k), b_wa, k % 5);
      check($sformatf("s5_ra_%0d", k), b_ra, (k - 1) % 5);
      tick();
      check($sformatf("s5_level_%0d", k), b_level, 1);
    end
    fb.write_valid = 1'b0;
    #1;
    check("s5_last",       fb.read_data, 8'h2B);
    tick();
    fb.read_ready = 1'b0;
    check("s5_empty",      b_empty, 1);

    // Mid-operation reset with transfers presented
    for (int i = 0; i < 9; i++) begin
      fa.write_valid = 1'b1; fa.write_data = 8'(8'h40 + i);
      tick();
    end
    check("pre_rst_level", a_level, 9);
    reset = 1'b1; fa.read_ready = 1'b1;
    tick();
    reset = 1'b0; fa.write_valid = 1'b0; fa.read_ready = 1'b0;
    #1;
    check("mr_level",      a_level, 0);
    check("mr_empty",      a_empty, 1);
    check("mr_wa",         a_wa, 0);
    check("mr_ra",         a_ra, 0);
    check("mr_rvalid",     fa.read_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
